// File: rtl/dct_transpose.sv
// dct_transpose: 4x4 ping-pong transpose buffer between the row and column
// passes of the 2-D 4-point DCT. Rows of IN_W-bit elements go in, columns of
// OUT_W-bit elements come out.
// Optional build macro: DCT_TRANSPOSE_SAT_EN. When defined, elements are
// saturated to the signed OUT_W range. When undefined, elements are truncated
// to their low OUT_W bits (two's-complement wrap).
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both high. The source holds its payload stable while valid & !ready. Neither
// ready depends combinationally on the other side's valid/ready. out_valid and
// out_col_* are driven only from registers and storage.
module dct_transpose #(
   parameter int IN_W  = 13,
   parameter int OUT_W = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_row [4],
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_col_data [4],
   output logic [1:0]              out_col_idx,
   output logic                    out_last
);

   // Two banks of 4 rows x 4 columns. The contents carry no reset; the full
   // flags alone decide what is meaningful.
   logic signed [IN_W-1:0] bank_mem [2][4][4];

   logic       wr_bank_q, wr_bank_d;
   logic [1:0] wr_row_q,  wr_row_d;
   logic       rd_bank_q, rd_bank_d;
   logic [1:0] rd_col_q,  rd_col_d;
   logic [1:0] full_q,    full_d;

   logic wr_fire;
   logic rd_fire;

   // Narrow one stored element to the output width.
   function automatic logic signed [OUT_W-1:0] convert(input logic signed [IN_W-1:0] x);
`ifdef DCT_TRANSPOSE_SAT_EN
      localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << (OUT_W - 1)) - 1);
      localparam logic signed [IN_W-1:0] SAT_MIN = ~SAT_MAX;
      if (x > SAT_MAX) begin
         convert = SAT_MAX[OUT_W-1:0];
      end else if (x < SAT_MIN) begin
         convert = SAT_MIN[OUT_W-1:0];
      end else begin
         convert = x[OUT_W-1:0];
      end
`else
      convert = x[OUT_W-1:0];
`endif
   endfunction

   // A bank is writable only while it is empty. A bank is readable only while it is full.
   assign in_ready  = ~full_q[wr_bank_q];
   assign out_valid = full_q[rd_bank_q];
   assign wr_fire   = in_valid & in_ready;
   assign rd_fire   = out_valid & out_ready;

   // Next-state for the write/read pointers and the per-bank full flags.
   always_comb begin
      wr_bank_d = wr_bank_q;
      wr_row_d  = wr_row_q;
      rd_bank_d = rd_bank_q;
      rd_col_d  = rd_col_q;
      full_d    = full_q;
      if (wr_fire) begin
         wr_row_d = wr_row_q + 2'd1;
         if (wr_row_q == 2'd3) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end
      end
      // Write and read banks always differ, so both flag updates can land in one cycle.
      if (rd_fire) begin
         rd_col_d = rd_col_q + 2'd1;
         if (rd_col_q == 2'd3) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
         end
      end
   end

   // Control state register. Reset discards any partial or undrained block.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank_q <= 1'b0;
         wr_row_q  <= 2'd0;
         rd_bank_q <= 1'b0;
         rd_col_q  <= 2'd0;
         full_q    <= 2'b00;
      end else begin
         wr_bank_q <= wr_bank_d;
         wr_row_q  <= wr_row_d;
         rd_bank_q <= rd_bank_d;
         rd_col_q  <= rd_col_d;
         full_q    <= full_d;
      end
   end

   // Capture an accepted row into the current write bank.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int k = 0; k < 4; k++) begin
            bank_mem[wr_bank_q][wr_row_q][k] <= in_row[k];
         end
      end
   end

   // Present the current column of the read bank. Outputs are zero while idle.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         out_col_data[r] = '0;
         if (out_valid) begin
            out_col_data[r] = convert(bank_mem[rd_bank_q][r][rd_col_q]);
         end
      end
      out_col_idx = rd_col_q;
      out_last    = out_valid & (rd_col_q == 2'd3);
   end

endmodule

// File: tb/tb_dct_transpose.sv
// tb_dct_transpose: directed and randomized checks of dct_transpose against a
// block-queue reference model. It also covers the DCT_TRANSPOSE_SAT_EN build
// when that macro is defined for the whole compile.
module tb_dct_transpose;

   localparam int IN_W  = 13;
   localparam int OUT_W = 12;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic signed [IN_W-1:0]  in_row [4];
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic signed [OUT_W-1:0] out_col_data [4];
   logic [1:0]              out_col_idx;
   logic                    out_last;

   int total = 0;
   int bad   = 0;

   // Reference model: a flat queue of completed blocks (16 elements each,
   // row-major), a partial block being filled, and the column being drained.
   int  elem_q[$];
   int  cur_blk [16];
   int  cur_cnt   = 0;
   int  rd_col    = 0;
   bit  model_ok  = 1'b0;
   bit  wr_fired  = 1'b0;
   logic signed [IN_W-1:0] cur_in [4];

   dct_transpose #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_row       (in_row),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_col_data (out_col_data),
      .out_col_idx  (out_col_idx),
      .out_last     (out_last)
   );

   // Clock
   always #5 clk = ~clk;

   function automatic int ref_conv(input int v);
      int t;
`ifdef DCT_TRANSPOSE_SAT_EN
      if (v > (1 << (OUT_W - 1)) - 1) return (1 << (OUT_W - 1)) - 1;
      if (v < -(1 << (OUT_W - 1)))    return -(1 << (OUT_W - 1));
      return v;
`else
      t = v % (1 << OUT_W);
      if (t < 0) t = t + (1 << OUT_W);
      if (t >= (1 << (OUT_W - 1))) t = t - (1 << OUT_W);
      return t;
`endif
   endfunction

   function automatic int nblk();
      return elem_q.size() / 16;
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      bit exp_v;
      int exp_d;
      exp_v = (nblk() > 0);
      chk("out_valid", {31'd0, out_valid}, exp_v ? 1 : 0);
      chk("in_ready", {31'd0, in_ready}, (nblk() < 2) ? 1 : 0);
      chk("out_col_idx", {30'd0, out_col_idx}, rd_col);
      chk("out_last", {31'd0, out_last}, (exp_v && rd_col == 3) ? 1 : 0);
      for (int r = 0; r < 4; r++) begin
         exp_d = exp_v ? ref_conv(elem_q[r * 4 + rd_col]) : 0;
         chk($sformatf("out_col_data[%0d]", r), $signed(out_col_data[r]), exp_d);
      end
   endtask

   task automatic new_row();
      for (int k = 0; k < 4; k++) cur_in[k] = IN_W'($urandom_range(0, (1 << IN_W) - 1));
   endtask

   // One clock cycle: drive at the falling edge, check, let the rising edge act, advance the model.
   task automatic step(input bit v, input bit ordy, input bit r);
      bit wr_f;
      bit rd_f;
      in_valid  = v;
      out_ready = ordy;
      rst       = r;
      for (int k = 0; k < 4; k++) in_row[k] = cur_in[k];
      #1;
      if (model_ok) check_outputs();
      wr_f = v && (nblk() < 2);
      rd_f = ordy && (nblk() > 0);
      @(posedge clk);
      wr_fired = 1'b0;
      if (r) begin
         elem_q.delete();
         cur_cnt  = 0;
         rd_col   = 0;
         model_ok = 1'b1;
      end else begin
         if (rd_f) begin
            rd_col++;
            if (rd_col == 4) begin
               rd_col = 0;
               for (int i = 0; i < 16; i++) void'(elem_q.pop_front());
            end
         end
         if (wr_f) begin
            wr_fired = 1'b1;
            for (int k = 0; k < 4; k++) cur_blk[cur_cnt * 4 + k] = int'(cur_in[k]);
            cur_cnt++;
            if (cur_cnt == 4) begin
               for (int i = 0; i < 16; i++) elem_q.push_back(cur_blk[i]);
               cur_cnt = 0;
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < 4; k++) cur_in[k] = '0;
      @(negedge clk);

      // Reset, then check the idle state.
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 0, 0);
      step(0, 1, 0);

      // Basic transpose: row r holds 10r+k.
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 4; k++) cur_in[k] = IN_W'(10 * r + k);
         step(1, 1, 0);
      end
      for (int i = 0; i < 5; i++) step(0, 1, 0);

      // Streaming: three back-to-back blocks.
      for (int i = 0; i < 12; i++) begin
         new_row();
         step(1, 1, 0);
      end
      for (int i = 0; i < 6; i++) step(0, 1, 0);

      // Backpressure: both banks fill, then the ninth row is held off.
      new_row();
      for (int i = 0; i < 11; i++) begin
         step(1, 0, 0);
         if (wr_fired) new_row();
      end
      for (int i = 0; i < 14; i++) begin
         step(1, 1, 0);
         if (wr_fired) new_row();
      end
      for (int i = 0; i < 10; i++) step(0, 1, 0);

      // Stall stability at column 2.
      for (int r = 0; r < 4; r++) begin
         new_row();
         step(1, 0, 0);
      end
      step(0, 1, 0);
      step(0, 1, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0);
      step(0, 1, 0);
      step(0, 1, 0);
      step(0, 1, 0);

      // Conversion corner values.
      cur_in[0] = 13'sd2100;
      cur_in[1] = -13'sd4096;
      cur_in[2] = -13'sd37;
      cur_in[3] = 13'sd2047;
      step(1, 1, 0);
      cur_in[0] = -13'sd2048;
      cur_in[1] = -13'sd2049;
      cur_in[2] = 13'sd2048;
      cur_in[3] = 13'sd4095;
      step(1, 1, 0);
      for (int r = 0; r < 2; r++) begin
         new_row();
         step(1, 1, 0);
      end
      for (int i = 0; i < 5; i++) step(0, 1, 0);

      // Reset mid-block, then a fresh block.
      for (int r = 0; r < 2; r++) begin
         new_row();
         step(1, 1, 0);
      end
      step(0, 1, 1);
      step(0, 0, 0);
      for (int r = 0; r < 4; r++) begin
         new_row();
         step(1, 1, 0);
      end
      for (int i = 0; i < 5; i++) step(0, 1, 0);

      // Random traffic on both sides.
      new_row();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0);
         if (wr_fired) new_row();
      end
      for (int i = 0; i < 10; i++) step(0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dct_transpose.md
Name: dct_transpose

Overview:
- 4x4 transpose buffer between the 1-D row pass (renormalization output, 4 x 13-bit signed per row) and the column pass of the 2-D 4-point DCT.
- Accepts one 4-element row per handshake and, once 4 rows are collected, emits the block as 4 columns, one per handshake.
- Ping-pong (two-bank) storage, so one block can be filled while the other drains. Sustained throughput is 1 row/cycle in and 1 column/cycle out.

Parameters:
- IN_W, 13, signed width of each input element (matches renorm output).
- OUT_W, 12, signed width of each output element (column-pass input); OUT_W <= IN_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  row present on in_row
- in_ready  out  1  buffer can accept a row this cycle
- in_row[4]  in  IN_W each, signed  row elements, index k = column
- out_valid  out  1  column present on out_col_data
- out_ready  in  1  consumer accepts column this cycle
- out_col_data[4]  out  OUT_W each, signed  column elements, index r = source row
- out_col_idx  out  2  column number 0..3 being presented
- out_last  out  1  high with column 3 of a block

Behaviour:
- Storage is bank[2][4 rows][4 cols] x IN_W; storage is not reset.
- State: wr_bank (1b), wr_row (2b), rd_bank (1b), rd_col (2b), full[2].
- Reset: all state cleared to 0; out_valid=0, out_col_data=0, out_col_idx=0, out_last=0, in_ready=1.
- in_ready = !full[wr_bank]. It is a pure register decode, with no combinational path from out_ready.
- Write on in_valid & in_ready:
  - bank[wr_bank][wr_row][k] <= in_row[k] for k=0..3; wr_row++.
  - If wr_row==3: full[wr_bank] <= 1, wr_bank toggles, wr_row <= 0.
- out_valid = full[rd_bank].
- out_col_data[r] = convert(bank[rd_bank][r][rd_col]) when out_valid, else 0.
- out_col_idx = rd_col; out_last = out_valid & (rd_col==3).
- Read on out_valid & out_ready:
  - rd_col++.
  - If rd_col==3: full[rd_bank] <= 0, rd_bank toggles, rd_col <= 0.
- Latency: column 0 is valid in the cycle after the handshake of row 3.
- Stall: while out_ready=0, out_col_data, out_col_idx and out_last hold stable.
- Both banks full: in_ready=0 until the read side releases a bank. The freed bank's in_ready rises the cycle after the release handshake (registered full flag).
- Simultaneous write-complete and read-release on different banks in the same cycle: both flags update independently. No loss, no double count.
- Write and read never target the same bank: the write bank is never full while written, and the read bank is always full while read.
- in_valid with in_ready=0: no state change; the row must be held by upstream.
- Reset mid-block: partial rows and undrained blocks are discarded; the next accepted row is row 0 of bank 0.
- Element conversion IN_W -> OUT_W: see Optional Feature. When OUT_W==IN_W, data passes unchanged.

Optional Feature:
- Macro: DCT_TRANSPOSE_SAT_EN.
- Defined: each element is saturated to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: each element is truncated to its low OUT_W bits (two's-complement wrap), with no extra logic.
- Identical behaviour for in-range values.

Test Plan:
- Basic transpose: rows r=0..3 with in_row[k]=10r+k, out_ready=1. Expect columns c=0..3 = {c, 10+c, 20+c, 30+c}, out_col_idx=c, out_last only at c=3, first out_valid in the cycle after row 3.
- Streaming: 3 back-to-back blocks with in_valid=1 and out_ready=1 throughout. Expect in_ready never drops, 12 columns out in order, no gaps after the first block.
- Backpressure: out_ready=0 while writing 8 rows. Expect in_ready=0 after the 8th row and a 9th row held off. Then raise out_ready: block 0 drains, in_ready returns the cycle after column 3 handshake, and block 1 follows.
- Stall stability: hold out_ready=0 for 5 cycles at column 2. Expect out_col_data/out_col_idx=2 unchanged, then resume with column 3.
- Conversion (OUT_W=12): element 2100 and -4096.
  - With DCT_TRANSPOSE_SAT_EN: 2047 and -2048.
  - Without it: -1996 and 0.
  - Element -37: -37 in both builds.
- Reset mid-block: assert rst after 2 rows. Expect out_valid=0 and in_ready=1 next cycle. A fresh 4 rows then produce the correct columns with no stale data.
